seq_frame_scheduler: RTL and testbench
======================================

// Module: seq_frame_scheduler
// PURPOSE
//  Feeds a serial sequence detector from a byte stream. Serialises a frame of
//  bytes MSB-first, one bit per clock, onto the detector's input bit.
//  Clears the detector at the start of each frame and counts its hit pulses.
//  Reports the frame's hit count with a one-cycle done pulse.
//  Sits between a byte source (valid/ready) and one detector instance.
// PARAMETERS
//  DATA_W   8  bits per input byte (>=2)
//  LEN_W    8  width of frame length (frame length is in bytes)
//  CNT_W    8  width of the hit counter (saturating)
//  HIT_LAT  1  cycles from det_bit/det_en to the matching det_hit (>=1)
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-low
//  start      in   1       begin a frame; honoured only in IDLE
//  frame_len  in   LEN_W   frame length in bytes, sampled with start
//  abort      in   1       cancel the frame in progress
//  in_valid   in   1       byte available
//  in_data    in   DATA_W  byte to serialise
//  in_ready   out  1       scheduler accepts in_data this cycle
//  det_bit    out  1       serial bit to the detector
//  det_en     out  1       det_bit is valid this cycle
//  det_clr    out  1       one-cycle synchronous clear to the detector
//  det_hit    in   1       detector match indication
//  busy       out  1       high in every state except IDLE
//  done       out  1       one-cycle pulse: frame complete
//  hit_count  out  CNT_W   hits in the last or current frame
//  state      out  3       FSM state, for debug
// BEHAVIOUR
//  Reset: state=IDLE and every output is 0, including hit_count. No register
//   is left undefined.
//  States (encoding): IDLE=0, CLR=1, LOAD=2, SHIFT=3, DRAIN=4, DONE=5.
//  IDLE: if start=1 and frame_len=0, go to DONE (hit_count=0, no det_clr).
//   If start=1 and frame_len>0, latch bytes_left=frame_len, clear hit_count,
//   go to CLR.
//  CLR: det_clr=1 for exactly one cycle, then go to LOAD.
//  LOAD: in_ready=1 and det_en=0. On in_valid&in_ready: shreg<=in_data,
//   bytes_left-=1, go to SHIFT.
//  SHIFT: det_en=1 and det_bit=shreg[DATA_W-1]; shreg shifts left each cycle.
//   The state lasts exactly DATA_W cycles.
//  Last bit cycle of SHIFT, bytes_left>0: in_ready=1.
//   - Byte accepted: reload and stay in SHIFT. The bit stream has no gap.
//   - No byte: go to LOAD, with a bubble where det_en=0.
//  Last bit cycle of SHIFT, bytes_left=0: go to DRAIN.
//  DRAIN: hold HIT_LAT cycles with det_en=0, then go to DONE.
//  DONE: done=1 for one cycle, then go to IDLE. hit_count holds until the
//   next accepted start.
//  Hit counting:
//   - det_en is delayed by HIT_LAT through a shift line (en_d).
//   - Count only when det_hit & en_d[HIT_LAT-1]; det_hit is ignored otherwise.
//   - Saturate at 2^CNT_W-1, no wrap.
//  abort: honoured in every state except IDLE and overrides everything.
//   - Same cycle: in_ready=0 and no byte accepted.
//   - Next cycle: state=IDLE, with det_clr=1 for that cycle.
//   - No done pulse; hit_count keeps its partial value.
//  start while busy is ignored; frame_len is not resampled.
//  abort and start together in IDLE: start wins, abort is ignored.
//  Asserting reset mid-frame returns to the reset values immediately.
//   No done pulse, no det_clr.
// STRUCTURE
//  Shared package seq_pkg: state enum/localparams (IDLE..DONE) and the
//   default widths DATA_W/LEN_W/CNT_W.
//  One natural sub-module, seq_hit_counter: the en_d delay line plus the
//   saturating counter, with ports clk, reset, clr, en, hit, count.
//  The FSM, shift register and bytes_left counter stay in the top module.
// TESTING
//  Bench stub detector: det_hit is det_bit&det_en registered once, so it
//   counts 1-bits (HIT_LAT=1). Defaults DATA_W=8, CNT_W=8.
//  1) len=1, byte 8'hA5:
//     det_bit order 1,0,1,0,0,1,0,1; det_clr one cycle before the first
//     bit; done once; hit_count=4.
//  2) len=3, bytes FF,00,0F, in_valid held high:
//     24 consecutive det_en cycles with no bubble; hit_count=12.
//  3) len=2, 5 idle cycles before the second byte:
//     state=LOAD with det_en=0 during the gap; hit_count matches the 1-bits
//     of both bytes.
//  4) len=0:
//     done two cycles after start; hit_count=0; det_en never set.
//  5) abort on the 3rd SHIFT cycle of byte 8'hFF:
//     IDLE next cycle, det_clr=1, no done, hit_count<=3.
//  6) CNT_W=4, len=2, bytes FF,FF:
//     hit_count saturates at 15.
//  Also: reset low mid-SHIFT gives all outputs 0 at once; start while busy
//   is ignored.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the frame scheduler: FSM state encoding and the
// default datapath widths.
package seq_pkg;

   localparam int SEQ_DATA_W = 8;
   localparam int SEQ_LEN_W  = 8;
   localparam int SEQ_CNT_W  = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/seq_hit_counter.sv
// Saturating hit counter. The bit-enable is delayed by the detector latency
// so that only hits belonging to a serialised bit are counted.
module seq_hit_counter #(
   parameter int CNT_W   = 8,
   parameter int HIT_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             hit,
   output logic [CNT_W-1:0] count
);

   logic [HIT_LAT-1:0] en_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_d  <= '0;
         count <= '0;
      end else begin
         en_d <= (en_d << 1) | HIT_LAT'(en);
         if (clr)
            count <= '0;
         else if (hit && en_d[HIT_LAT-1] && (count != '1))
            count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_frame_scheduler.sv
// Serialises a frame of bytes MSB-first into a sequence detector, clears the
// detector at frame start and reports the number of hits seen in the frame.
module seq_frame_scheduler
   import seq_pkg::*;
#(
   parameter int DATA_W  = SEQ_DATA_W,
   parameter int LEN_W   = SEQ_LEN_W,
   parameter int CNT_W   = SEQ_CNT_W,
   parameter int HIT_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  frame_len,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              det_bit,
   output logic              det_en,
   output logic              det_clr,
   input  logic              det_hit,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  hit_count,
   output logic [2:0]        state
);

   localparam int BIT_W = $clog2(DATA_W);
   localparam int DRN_W = (HIT_LAT > 1) ? $clog2(HIT_LAT) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_W - 1);
   localparam logic [DRN_W-1:0] LAST_DRAIN = DRN_W'(HIT_LAT - 1);

   state_t            st_q, st_d;
   logic [DATA_W-1:0] shreg;
   logic [LEN_W-1:0]  bytes_left;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DRN_W-1:0]  drain_cnt;
   logic              abort_clr;
   logic              last_bit, more_bytes, abort_hit, accept, cnt_clr;

   assign last_bit   = (bit_cnt == LAST_BIT);
   assign more_bytes = (bytes_left != '0);
   assign abort_hit  = abort && (st_q != ST_IDLE);
   assign accept     = in_valid && in_ready;
   assign cnt_clr    = (st_q == ST_IDLE) && start;
   assign state      = st_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) st_q <= ST_IDLE;
      else        st_q <= st_d;
   end

   // Abort wins over every transition out of a busy state.
   always_comb begin
      st_d = st_q;
      if (abort_hit) begin
         st_d = ST_IDLE;
      end else begin
         case (st_q)
            ST_IDLE:  if (start) st_d = (frame_len == '0) ? ST_DONE : ST_CLR;
            ST_CLR:   st_d = ST_LOAD;
            ST_LOAD:  if (in_valid) st_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) begin
                         if (!more_bytes)    st_d = ST_DRAIN;
                         else if (!in_valid) st_d = ST_LOAD;
                      end
            ST_DRAIN: if (drain_cnt == LAST_DRAIN) st_d = ST_DONE;
            ST_DONE:  st_d = ST_IDLE;
            default:  st_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready = 1'b0;
      det_en   = 1'b0;
      det_bit  = 1'b0;
      det_clr  = abort_clr;
      busy     = (st_q != ST_IDLE);
      done     = 1'b0;
      case (st_q)
         ST_CLR:   det_clr  = 1'b1;
         ST_LOAD:  in_ready = !abort;
         ST_SHIFT: begin
            det_en   = 1'b1;
            det_bit  = shreg[DATA_W-1];
            in_ready = last_bit && more_bytes && !abort;
         end
         ST_DONE:  done = !abort;
         default:  ;
      endcase
   end

   // A reload on the last bit cycle keeps the serial stream gap-free.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg      <= '0;
         bytes_left <= '0;
         bit_cnt    <= '0;
         drain_cnt  <= '0;
         abort_clr  <= 1'b0;
      end else begin
         abort_clr <= abort_hit;
         drain_cnt <= (st_q == ST_DRAIN) ? drain_cnt + DRN_W'(1) : '0;
         if ((st_q == ST_IDLE) && start && (frame_len != '0)) begin
            bytes_left <= frame_len;
         end else if (accept) begin
            shreg      <= in_data;
            bytes_left <= bytes_left - LEN_W'(1);
            bit_cnt    <= '0;
         end else if (st_q == ST_SHIFT) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + BIT_W'(1);
         end
      end
   end

   seq_hit_counter #(
      .CNT_W   (CNT_W),
      .HIT_LAT (HIT_LAT)
   ) u_hit_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (det_en),
      .hit   (det_hit),
      .count (hit_count)
   );

endmodule

// File: tb/tb_seq_frame_scheduler.sv
// Bench for seq_frame_scheduler: a stub detector that reports every serialised
// 1-bit one cycle later, plus a second instance with a 4-bit hit counter.
module tb_seq_frame_scheduler;

   localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd2, S_SHIFT = 3'd3;

   logic       clk, reset, start, abort, in_valid;
   logic [7:0] frame_len, in_data;
   logic       in_ready, det_bit, det_en, det_clr, det_hit, busy, done;
   logic [7:0] hit_count;
   logic [2:0] state;
   logic       s_in_ready, s_det_bit, s_det_en, s_det_clr, s_det_hit, s_busy, s_done;
   logic [3:0] s_hit_count;
   logic [2:0] s_state;

   int checks = 0, errors = 0;
   logic [7:0] tx_q[$];
   logic [0:0] exp_q[$];
   logic [0:0] obs_q[$];
   int  en_cnt, clr_cnt, done_cnt, first_clr, first_en, done_cyc, bubbles, bubble_bad;
   int  rec_abort_ready, rec_after_state, rec_after_clr;
   bit  ended;

   seq_frame_scheduler #(.DATA_W(8), .LEN_W(8), .CNT_W(8), .HIT_LAT(1)) dut (
      .clk(clk), .reset(reset), .start(start), .frame_len(frame_len), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .det_bit(det_bit),
      .det_en(det_en), .det_clr(det_clr), .det_hit(det_hit), .busy(busy), .done(done),
      .hit_count(hit_count), .state(state));

   seq_frame_scheduler #(.DATA_W(8), .LEN_W(8), .CNT_W(4), .HIT_LAT(1)) dut_sat (
      .clk(clk), .reset(reset), .start(start), .frame_len(frame_len), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready), .det_bit(s_det_bit),
      .det_en(s_det_en), .det_clr(s_det_clr), .det_hit(s_det_hit), .busy(s_busy), .done(s_done),
      .hit_count(s_hit_count), .state(s_state));

   // Stub detectors: a hit for every 1-bit, one cycle late.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         det_hit   <= 1'b0;
         s_det_hit <= 1'b0;
      end else begin
         det_hit   <= det_bit & det_en;
         s_det_hit <= s_det_bit & s_det_en;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int build_expect();
      int pop = 0;
      exp_q.delete();
      foreach (tx_q[i]) begin
         for (int b = 7; b >= 0; b--) begin
            exp_q.push_back(tx_q[i][b]);
            pop += int'(tx_q[i][b]);
         end
      end
      return pop;
   endfunction

   function automatic int stream_diffs();
      int d = 0;
      if (obs_q.size() != exp_q.size()) return 1000 + obs_q.size();
      foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) d++;
      return d;
   endfunction

   // Drives one frame from tx_q and records what the scheduler emits.
   task automatic run_frame(input int len, input int gap, input int abort_at,
                            input int restart_at, input bit stall_rnd);
      int idx, gap_left, shift_seen, tail, pend, pend_bad, abort_cyc;
      bit aborted, stall;
      idx = 0; gap_left = gap; shift_seen = 0; tail = -1; pend = 0; pend_bad = 0;
      abort_cyc = -10; aborted = 0;
      obs_q.delete(); en_cnt = 0; clr_cnt = 0; done_cnt = 0; first_clr = -1; first_en = -1;
      done_cyc = -1; bubbles = 0; bubble_bad = 0;
      rec_abort_ready = -1; rec_after_state = -1; rec_after_clr = -1; ended = 0;
      for (int cyc = 0; cyc < 400 && !ended; cyc++) begin
         @(posedge clk); #1;
         start     = (cyc == 0) || (cyc == restart_at);
         frame_len = (cyc == 0) ? 8'(len) : 8'd5;
         if (state == S_SHIFT) shift_seen++;
         abort    = (abort_at > 0) && !aborted && (state == S_SHIFT) && (shift_seen == abort_at);
         stall    = stall_rnd && ($urandom_range(0, 2) == 0);
         in_valid = (idx < tx_q.size()) && !(idx == 1 && gap_left > 0) && !stall;
         in_data  = in_valid ? tx_q[idx] : 8'($urandom);
         #1;
         if (in_valid && in_ready) idx++;
         if (idx == 1 && gap_left > 0 && !in_valid && in_ready) gap_left--;
         if (abort) begin
            aborted = 1; abort_cyc = cyc; rec_abort_ready = int'(in_ready);
         end
         if (cyc == abort_cyc + 1) begin
            rec_after_state = int'(state); rec_after_clr = int'(det_clr);
         end
         if (det_clr) begin
            clr_cnt++;
            if (first_clr < 0) first_clr = cyc;
         end
         if (det_en) begin
            obs_q.push_back(det_bit);
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            bubbles += pend; bubble_bad += pend_bad; pend = 0; pend_bad = 0;
         end else if (first_en >= 0) begin
            pend++;
            if (state != S_LOAD) pend_bad++;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (tail < 0 && (done || aborted)) tail = 3;
         else if (tail > 0) tail--;
         if (tail == 0) ended = 1;
      end
      start = 0; abort = 0; in_valid = 0; frame_len = 0;
      checks++;
      if (!ended) begin
         errors++;
         $display("FAIL frame_timeout: frame end not seen, ended=%0d required=1", ended);
      end
   endtask

   task automatic test_reset();
      start = 0; abort = 0; in_valid = 0; in_data = 0; frame_len = 0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      checks++;
      if ({in_ready, det_bit, det_en, det_clr, busy, done, hit_count, state} !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0",
                  {in_ready, det_bit, det_en, det_clr, busy, done, hit_count, state});
      end
      checks++;
      if (s_hit_count !== 4'd0) begin
         errors++; $display("FAIL reset_sat_count: got %0d required 0", s_hit_count);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (state !== S_IDLE || busy !== 1'b0) begin
         errors++; $display("FAIL reset_release_idle: state=%0d busy=%0d required 0/0", state, busy);
      end
   endtask

   task automatic test_single_byte();
      int pop;
      tx_q = '{8'hA5};
      pop = build_expect();
      run_frame(1, 0, 0, -1, 0);
      checks++;
      if (stream_diffs() != 0) begin
         errors++; $display("FAIL a5_bit_order: diffs=%0d required 0", stream_diffs());
      end
      checks++;
      if (clr_cnt != 1 || first_clr < 0 || first_clr >= first_en) begin
         errors++;
         $display("FAIL a5_clear: clr_cnt=%0d clr_cyc=%0d first_bit=%0d required one clear before first bit",
                  clr_cnt, first_clr, first_en);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++; $display("FAIL a5_done: got %0d pulses required 1", done_cnt);
      end
      checks++;
      if (hit_count !== 8'(pop) || pop != 4) begin
         errors++; $display("FAIL a5_hits: got %0d required 4", hit_count);
      end
   endtask

   task automatic test_back_to_back();
      int pop;
      tx_q = '{8'hFF, 8'h00, 8'h0F};
      pop = build_expect();
      run_frame(3, 0, 0, -1, 0);
      checks++;
      if (en_cnt != 24 || bubbles != 0) begin
         errors++; $display("FAIL b2b_stream: en=%0d bubbles=%0d required 24/0", en_cnt, bubbles);
      end
      checks++;
      if (stream_diffs() != 0) begin
         errors++; $display("FAIL b2b_bits: diffs=%0d required 0", stream_diffs());
      end
      checks++;
      if (hit_count !== 8'(pop)) begin
         errors++; $display("FAIL b2b_hits: got %0d required %0d", hit_count, pop);
      end
   endtask

   task automatic test_load_gap();
      int pop;
      tx_q = '{8'($urandom), 8'($urandom)};
      pop = build_expect();
      run_frame(2, 5, 0, -1, 0);
      checks++;
      if (bubbles != 5 || bubble_bad != 0) begin
         errors++;
         $display("FAIL gap_load_bubble: bubbles=%0d outside_load=%0d required 5/0", bubbles, bubble_bad);
      end
      checks++;
      if (stream_diffs() != 0 || hit_count !== 8'(pop)) begin
         errors++;
         $display("FAIL gap_hits: diffs=%0d hits=%0d required 0/%0d", stream_diffs(), hit_count, pop);
      end
   endtask

   task automatic test_zero_len();
      tx_q.delete();
      run_frame(0, 0, 0, -1, 0);
      checks++;
      if (done_cnt != 1 || done_cyc < 1 || done_cyc > 2) begin
         errors++; $display("FAIL zero_done: pulses=%0d at=%0d required 1 at 1..2", done_cnt, done_cyc);
      end
      checks++;
      if (en_cnt != 0 || clr_cnt != 0 || hit_count !== 8'd0) begin
         errors++;
         $display("FAIL zero_quiet: en=%0d clr=%0d hits=%0d required 0/0/0", en_cnt, clr_cnt, hit_count);
      end
   endtask

   task automatic test_abort();
      tx_q = '{8'hFF};
      run_frame(1, 0, 3, -1, 0);
      checks++;
      if (rec_abort_ready != 0) begin
         errors++; $display("FAIL abort_ready: got %0d required 0", rec_abort_ready);
      end
      checks++;
      if (rec_after_state != 0 || rec_after_clr != 1) begin
         errors++;
         $display("FAIL abort_next: state=%0d det_clr=%0d required 0/1", rec_after_state, rec_after_clr);
      end
      checks++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_no_done: done=%0d busy=%0d required 0/0", done_cnt, busy);
      end
      checks++;
      if (hit_count > 8'd3 || hit_count < 8'd2) begin
         errors++; $display("FAIL abort_hits: got %0d required 2..3", hit_count);
      end
   endtask

   task automatic test_saturate();
      int pop;
      tx_q = '{8'hFF, 8'hFF};
      pop = build_expect();
      run_frame(2, 0, 0, -1, 0);
      checks++;
      if (s_hit_count !== 4'(pop > 15 ? 15 : pop)) begin
         errors++; $display("FAIL sat_count: got %0d required 15", s_hit_count);
      end
      checks++;
      if (hit_count !== 8'(pop)) begin
         errors++; $display("FAIL sat_wide_count: got %0d required %0d", hit_count, pop);
      end
   endtask

   task automatic test_busy_start();
      int pop;
      tx_q = '{8'($urandom), 8'($urandom)};
      pop = build_expect();
      run_frame(2, 0, 0, 6, 0);
      checks++;
      if (en_cnt != 16 || done_cnt != 1 || clr_cnt != 1) begin
         errors++;
         $display("FAIL busy_start: en=%0d done=%0d clr=%0d required 16/1/1", en_cnt, done_cnt, clr_cnt);
      end
      checks++;
      if (stream_diffs() != 0 || hit_count !== 8'(pop)) begin
         errors++;
         $display("FAIL busy_start_hits: diffs=%0d hits=%0d required 0/%0d", stream_diffs(), hit_count, pop);
      end
   endtask

   task automatic test_random();
      int len, pop, exp_hit;
      for (int f = 0; f < 6; f++) begin
         len = $urandom_range(1, 4);
         tx_q.delete();
         for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
         pop = build_expect();
         exp_hit = (pop > 255) ? 255 : pop;
         run_frame(len, 0, 0, -1, 1);
         checks++;
         if (stream_diffs() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL rand_stream[%0d]: diffs=%0d done=%0d required 0/1", f, stream_diffs(), done_cnt);
         end
         checks++;
         if (hit_count !== 8'(exp_hit)) begin
            errors++; $display("FAIL rand_hits[%0d]: got %0d required %0d", f, hit_count, exp_hit);
         end
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      @(posedge clk); #1;
      start = 1; frame_len = 8'd2;
      @(posedge clk); #1;
      start = 0; frame_len = 0; in_valid = 1; in_data = 8'hFF;
      for (int c = 0; c < 30 && seen < 4; c++) begin
         @(posedge clk); #1;
         if (state == S_SHIFT) seen++;
      end
      checks++;
      if (seen < 4 || hit_count == 8'd0) begin
         errors++; $display("FAIL mid_setup: shift_cycles=%0d hits=%0d required 4/nonzero", seen, hit_count);
      end
      #2 reset = 1'b0;
      in_valid = 0;
      #1;
      checks++;
      if ({in_ready, det_bit, det_en, det_clr, busy, done, hit_count, state} !== 15'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %h required 0",
                  {in_ready, det_bit, det_en, det_clr, busy, done, hit_count, state});
      end
      repeat (2) @(negedge clk);
      checks++;
      if (det_clr !== 1'b0 || done !== 1'b0 || state !== S_IDLE || s_hit_count !== 4'd0) begin
         errors++;
         $display("FAIL mid_reset_hold: clr=%0d done=%0d state=%0d sat=%0d required 0/0/0/0",
                  det_clr, done, state, s_hit_count);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_load_gap();
      test_zero_len();
      test_abort();
      test_saturate();
      test_busy_start();
      test_random();
      test_reset_mid();
      test_single_byte();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
